// File: rtl/mdio_pkg.sv
// Shared MDIO definitions: Clause-22 frame fields, BMSR bit positions, the
// link-monitor FSM state type and a read-frame builder.
// No ports; imported by the link monitor and its sub-module.
package mdio_pkg;

    localparam logic [1:0] ST       = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] TA       = 2'b10;
    localparam logic [4:0] REG_BMSR = 5'd1;

    localparam int BMSR_LINK_BIT = 2;
    localparam int BMSR_RF_BIT   = 4;
    localparam int BMSR_ANC_BIT  = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_RX = 2'd2,
        UPDATE  = 2'd3
    } mon_state_t;

    // Clause-22 read frame; the data field is zero because the PHY drives it.
    function automatic logic [31:0] build_read_frame(input logic [4:0] phy,
                                                     input logic [4:0] reg_addr);
        return {ST, OP_READ, phy, reg_addr, TA, 16'h0000};
    endfunction

endpackage

// File: rtl/mdio_link_monitor_if.sv
// Frame/response channel between the link monitor and the MDIO controller.
// master: monitor side (drives frame_data/frame_valid, receives ready and read data).
// slave:  controller side (mirror of master).
interface mdio_link_monitor_if;
    logic [31:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [15:0] rx_data;
    logic        rx_valid;

    modport master (
        output frame_data,
        output frame_valid,
        input  frame_ready,
        input  rx_data,
        input  rx_valid
    );

    modport slave (
        input  frame_data,
        input  frame_valid,
        output frame_ready,
        output rx_data,
        output rx_valid
    );
endinterface

// File: rtl/mdio_poll_timer.sv
// Poll interval counter: counts while run_i, clear_i forces it to zero.
// Latency: tc_o is combinational on the current count (high on the terminal cycle).
// Backpressure: none; the count saturates at the terminal value instead of wrapping.
// Ports: clk, reset (async high), run_i, clear_i, tc_o.
module mdio_poll_timer #(
    parameter int POLL_INTERVAL = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    input  logic clear_i,
    output logic tc_o
);
    localparam int W = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
    localparam logic [W-1:0] TERM = W'(POLL_INTERVAL - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i && (cnt_q != TERM)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = run_i && (cnt_q == TERM);

endmodule

// File: rtl/mdio_link_monitor.sv
// Periodic BMSR poller: issues Clause-22 reads and publishes decoded link state.
// Latency: poll start -> frame_valid next cycle; rx_valid -> status_valid two cycles later.
// Backpressure: frame held stable until frame_ready; read abandoned after RX_TIMEOUT cycles.
// Ports: clk, reset (async high), enable, poll_now, phy_addr, mdio (frame/rx channel,
// master side), status_reg/status_valid, link_up, an_complete, remote_fault,
// link_change, timeout_err. Build macro MDIO_LINK_MON_IRQ_EN adds sticky irq/irq_clear.
module mdio_link_monitor
    import mdio_pkg::*;
#(
    parameter int POLL_INTERVAL = 1000000,
    parameter int RX_TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        poll_now,
    input  logic [4:0]  phy_addr,
    mdio_link_monitor_if.master mdio,
    output logic [15:0] status_reg,
    output logic        status_valid,
    output logic        link_up,
    output logic        an_complete,
    output logic        remote_fault,
    output logic        link_change,
`ifdef MDIO_LINK_MON_IRQ_EN
    output logic        irq,
    input  logic        irq_clear,
`endif
    output logic        timeout_err
);
    localparam int TO_W = $clog2(RX_TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_TERM = TO_W'(RX_TIMEOUT - 1);

    mon_state_t      state_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [15:0]     rx_q;
    logic [31:0]     frame_data_q;
    logic            frame_valid_q;
    logic [15:0]     status_q;
    logic            status_valid_q;
    logic            link_up_q;
    logic            an_complete_q;
    logic            remote_fault_q;
    logic            link_change_q;
    logic            timeout_err_q;

    logic timer_tc;
    logic start_d;

    // poll_now bypasses enable; the periodic terminal count only fires while enabled.
    assign start_d = (state_q == IDLE) && (poll_now || timer_tc);

    mdio_poll_timer #(
        .POLL_INTERVAL (POLL_INTERVAL)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .run_i   ((state_q == IDLE) && enable),
        .clear_i (start_d),
        .tc_o    (timer_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            to_cnt_q       <= '0;
            rx_q           <= '0;
            frame_data_q   <= '0;
            frame_valid_q  <= 1'b0;
            status_q       <= '0;
            status_valid_q <= 1'b0;
            link_up_q      <= 1'b0;
            an_complete_q  <= 1'b0;
            remote_fault_q <= 1'b0;
            link_change_q  <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            status_valid_q <= 1'b0;
            link_change_q  <= 1'b0;
            timeout_err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        state_q       <= ISSUE;
                        frame_data_q  <= build_read_frame(phy_addr, REG_BMSR);
                        frame_valid_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (mdio.frame_ready) begin
                        state_q       <= WAIT_RX;
                        frame_valid_q <= 1'b0;
                        to_cnt_q      <= '0;
                    end
                end
                WAIT_RX: begin
                    // Data arriving on the final allowed cycle is still taken.
                    if (mdio.rx_valid) begin
                        rx_q    <= mdio.rx_data;
                        state_q <= UPDATE;
                    end else if (to_cnt_q == TO_TERM) begin
                        timeout_err_q <= 1'b1;
                        state_q       <= IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                UPDATE: begin
                    status_q       <= rx_q;
                    status_valid_q <= 1'b1;
                    link_up_q      <= rx_q[BMSR_LINK_BIT];
                    an_complete_q  <= rx_q[BMSR_ANC_BIT];
                    remote_fault_q <= rx_q[BMSR_RF_BIT];
                    link_change_q  <= rx_q[BMSR_LINK_BIT] ^ link_up_q;
                    state_q        <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef MDIO_LINK_MON_IRQ_EN
    logic irq_q;

    // Sticky: set from the visible event pulses; a set beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (link_change_q || timeout_err_q) begin
            irq_q <= 1'b1;
        end else if (irq_clear) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`endif

    assign mdio.frame_data  = frame_data_q;
    assign mdio.frame_valid = frame_valid_q;
    assign status_reg       = status_q;
    assign status_valid     = status_valid_q;
    assign link_up          = link_up_q;
    assign an_complete      = an_complete_q;
    assign remote_fault     = remote_fault_q;
    assign link_change      = link_change_q;
    assign timeout_err      = timeout_err_q;

endmodule

// File: tb/tb_mdio_link_monitor.sv
// Bench for mdio_link_monitor: directed periodic poll, table of poll_now
// transactions, random transactions against a transaction-level model,
// async reset in WAIT_RX/ISSUE and (with MDIO_LINK_MON_IRQ_EN) the sticky irq.
module tb_mdio_link_monitor;
    localparam int PI  = 8;
    localparam int RXT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        poll_now = 1'b0;
    logic [4:0]  phy_addr = 5'd0;
    logic [15:0] status_reg;
    logic        status_valid, link_up, an_complete, remote_fault, link_change, timeout_err;
`ifdef MDIO_LINK_MON_IRQ_EN
    logic        irq;
    logic        irq_clear = 1'b0;
`endif

    mdio_link_monitor_if mif();

    mdio_link_monitor #(
        .POLL_INTERVAL (PI),
        .RX_TIMEOUT    (RXT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .poll_now     (poll_now),
        .phy_addr     (phy_addr),
        .mdio         (mif),
        .status_reg   (status_reg),
        .status_valid (status_valid),
        .link_up      (link_up),
        .an_complete  (an_complete),
        .remote_fault (remote_fault),
        .link_change  (link_change),
`ifdef MDIO_LINK_MON_IRQ_EN
        .irq          (irq),
        .irq_clear    (irq_clear),
`endif
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction-level model state: last accepted BMSR value and link bit.
    logic [15:0] m_status = 16'h0;
    logic        m_link   = 1'b0;

    typedef struct {
        logic [4:0]  phy;
        logic [15:0] rx;
        int          rdy_dly;
        int          rx_dly;   // >= RXT means the PHY never answers
        logic [15:0] e_st;
        logic        e_lu, e_anc, e_rf, e_lc;
    } vec_t;

    vec_t vecs[7];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_frame(input logic [4:0] phy);
        return {2'b01, 2'b10, phy, 5'd1, 2'b10, 16'h0000};
    endfunction

    task automatic chk_all_zero(input string nm);
        chk({nm, "_frame"}, mif.frame_data, 32'h0);
        chk({nm, "_outs"}, {9'h0, mif.frame_valid, status_reg, status_valid, link_up,
                            an_complete, remote_fault, link_change, timeout_err}, 32'h0);
    endtask

    task automatic wait_frame(output int n);
        n = 0;
        while (!mif.frame_valid && n < 50) begin
            tick;
            n++;
        end
    endtask

    task automatic start_poll(input logic [4:0] phy);
        phy_addr = phy;
        poll_now = 1'b1;
        tick;
        poll_now = 1'b0;
        phy_addr = ~phy;
        chk("poll_latency", mif.frame_valid, 1);
        chk("frame_data", mif.frame_data, exp_frame(phy));
    endtask

    task automatic accept;
        mif.frame_ready = 1'b1;
        tick;
        mif.frame_ready = 1'b0;
    endtask

    // Completes a transaction whose frame is already being offered.
    task automatic finish_txn(input logic [4:0] phy, input logic [15:0] rx,
                              input int rdy_dly, input int rx_dly,
                              input logic [15:0] e_st, input logic e_lu,
                              input logic e_anc, input logic e_rf, input logic e_lc);
        int  n;
        bit  stray;
        stray = 1'b0;
        for (int i = 0; i < rdy_dly; i++) begin
            tick;
            if (!mif.frame_valid || mif.frame_data !== exp_frame(phy)) stray = 1'b1;
        end
        chk("frame_hold", {31'h0, stray}, 0);
        accept;
        chk("valid_drop", mif.frame_valid, 0);
        stray = 1'b0;
        if (rx_dly < RXT) begin
            for (int t = 0; t < rx_dly; t++) begin
                poll_now = (t == 0);
                tick;
                poll_now = 1'b0;
                if (status_valid || timeout_err || mif.frame_valid) stray = 1'b1;
            end
            mif.rx_valid = 1'b1;
            mif.rx_data  = rx;
            tick;
            mif.rx_valid = 1'b0;
            mif.rx_data  = 16'($urandom);
            if (status_valid || timeout_err) stray = 1'b1;
            chk("wait_quiet", {31'h0, stray}, 0);
            tick;
            chk("status_valid", status_valid, 1);
            chk("timeout_err", timeout_err, 0);
        end else begin
            n = 0;
            poll_now = 1'b1;
            while (!timeout_err && n < 40) begin
                tick;
                poll_now = 1'b0;
                n++;
                if (status_valid) stray = 1'b1;
            end
            chk("timeout_cycles", n, RXT);
            chk("no_status_on_timeout", {31'h0, stray}, 0);
        end
        chk("status_reg", status_reg, e_st);
        chk("link_up", link_up, e_lu);
        chk("an_complete", an_complete, e_anc);
        chk("remote_fault", remote_fault, e_rf);
        chk("link_change", link_change, e_lc);
        tick;
        chk("pulses_end", {status_valid, link_change, timeout_err, mif.frame_valid}, 0);
    endtask

    // Model step: what the outputs must be after a transaction with this read.
    task automatic model_txn(input logic [15:0] rx, input int rx_dly, output logic e_lc);
        e_lc = 1'b0;
        if (rx_dly < RXT) begin
            e_lc     = rx[2] ^ m_link;
            m_status = rx;
            m_link   = rx[2];
        end
    endtask

    initial begin
        int   n;
        bit   stray;
        logic lc;
        logic [4:0]  rphy;
        logic [15:0] rrx;
        int   rrdy, rrxd;

        mif.frame_ready = 1'b0;
        mif.rx_valid    = 1'b0;
        mif.rx_data     = 16'h0;

        vecs[0] = '{5'h05, 16'h7829, 1, 3,  16'h7829, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{5'h11, 16'hFFFF, 0, 20, 16'h7829, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{5'h1F, 16'h0014, 0, 15, 16'h0014, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{5'h00, 16'h0020, 2, 0,  16'h0020, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{5'h0C, 16'h0004, 1, 16, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{5'h0A, 16'h0004, 3, 7,  16'h0004, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{5'h15, 16'h782D, 0, 1,  16'h782D, 1'b1, 1'b1, 1'b0, 1'b0};

        repeat (3) tick;
        chk_all_zero("reset");

        // Periodic poll from reset.
        enable   = 1'b1;
        phy_addr = 5'h03;
        reset    = 1'b0;
        wait_frame(n);
        chk("first_poll_cycle", n, PI);
        chk("first_frame", mif.frame_data, 32'h6186_0000);
        finish_txn(5'h03, 16'h782D, 5, 2, 16'h782D, 1'b1, 1'b1, 1'b0, 1'b1);

        // Second periodic poll; enable drops mid-transaction.
        wait_frame(n);
        chk("second_poll_cycle", n, PI - 1);
        enable = 1'b0;
        finish_txn(5'h03, 16'h7829, 0, 0, 16'h7829, 1'b0, 1'b1, 1'b0, 1'b1);
        stray = 1'b0;
        repeat (20) begin
            tick;
            if (mif.frame_valid) stray = 1'b1;
        end
        chk("no_poll_after_disable", {31'h0, stray}, 0);

        foreach (vecs[i]) begin
            start_poll(vecs[i].phy);
            finish_txn(vecs[i].phy, vecs[i].rx, vecs[i].rdy_dly, vecs[i].rx_dly,
                       vecs[i].e_st, vecs[i].e_lu, vecs[i].e_anc, vecs[i].e_rf, vecs[i].e_lc);
        end
        m_status = 16'h782D;
        m_link   = 1'b1;

        // rx_valid and frame_ready outside their states are ignored.
        mif.rx_valid    = 1'b1;
        mif.rx_data     = 16'h0000;
        mif.frame_ready = 1'b1;
        tick;
        mif.rx_valid    = 1'b0;
        mif.frame_ready = 1'b0;
        stray = 1'b0;
        repeat (4) begin
            tick;
            if (status_valid || mif.frame_valid) stray = 1'b1;
        end
        chk("idle_ignores", {31'h0, stray}, 0);
        chk("idle_status_kept", status_reg, 16'h782D);

        // Random transactions against the model.
        for (int k = 0; k < 40; k++) begin
            rphy = 5'($urandom);
            rrx  = 16'($urandom);
            rrdy = $urandom_range(0, 4);
            rrxd = $urandom_range(0, RXT + 3);
            model_txn(rrx, rrxd, lc);
            start_poll(rphy);
            finish_txn(rphy, rrx, rrdy, rrxd, m_status, m_link,
                       m_status[5], m_status[4], lc);
        end

`ifdef MDIO_LINK_MON_IRQ_EN
        irq_clear = 1'b1;
        tick;
        irq_clear = 1'b0;
        chk("irq_cleared", irq, 0);
        rrx = m_link ? 16'h0000 : 16'h0004;
        model_txn(rrx, 0, lc);
        start_poll(5'h02);
        accept;
        mif.rx_valid = 1'b1;
        mif.rx_data  = rrx;
        tick;
        mif.rx_valid = 1'b0;
        tick;
        chk("irq_lc_seen", link_change, 1);
        irq_clear = 1'b1;
        tick;
        irq_clear = 1'b0;
        chk("irq_set_wins", irq, 1);
        irq_clear = 1'b1;
        tick;
        irq_clear = 1'b0;
        chk("irq_clear_alone", irq, 0);
`endif

        // Known non-zero status, then async reset while waiting for data.
        model_txn(16'h782D, 1, lc);
        start_poll(5'h07);
        finish_txn(5'h07, 16'h782D, 0, 1, 16'h782D, 1'b1, 1'b1, 1'b0, lc);
        start_poll(5'h07);
        accept;
        tick;
        #2 reset = 1'b1;
        #1;
        chk_all_zero("reset_wait_rx");
        tick;
        reset = 1'b0;
        m_status = 16'h0;
        m_link   = 1'b0;

        // Async reset while the frame is offered.
        start_poll(5'h09);
        #2 reset = 1'b1;
        #1;
        chk("reset_issue_valid", mif.frame_valid, 0);
        tick;
        reset = 1'b0;

        // First read after reset with link up pulses link_change.
        model_txn(16'h0024, 2, lc);
        start_poll(5'h09);
        finish_txn(5'h09, 16'h0024, 1, 2, 16'h0024, 1'b1, 1'b1, 1'b0, lc);
        chk("first_after_reset_lc", lc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
